// File: rtl/writeback_regfile_pkg.sv
// Shared definitions for the write-back stage and register file.
// The MemtoReg encodings are also used by the control unit and MEM/WB register.
package writeback_regfile_pkg;

    localparam int WB_B     = 32;
    localparam int WB_N_REG = 32;
    localparam int WB_A     = 5;

    localparam int REG_ZERO = 0;

    localparam logic MEMTOREG_MEM = 1'b1;
    localparam logic MEMTOREG_ALU = 1'b0;

endpackage

// File: rtl/writeback_regfile_mux_memtoreg.sv
// Write-back data select: memory load data or ALU result.
module writeback_regfile_mux_memtoreg
    import writeback_regfile_pkg::*;
#(
    parameter int B = WB_B
) (
    input  logic         mem_to_reg,
    input  logic [B-1:0] read_data,
    input  logic [B-1:0] alu_result,
    output logic [B-1:0] wb_data
);

    // Pure 2:1 select; no state.
    always_comb begin
        wb_data = alu_result;
        if (mem_to_reg == MEMTOREG_MEM) begin
            wb_data = read_data;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage plus 32-entry register file with two combinational read
// ports. A commit in flight is bypassed onto the read ports so ID sees the
// retiring value in the same cycle. r0 is hard-wired to zero.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int B     = WB_B,
    parameter int N_REG = WB_N_REG,
    parameter int A     = WB_A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [B-1:0] read_data_in,
    input  logic [B-1:0] alu_result_in,
    input  logic [B-1:0] mux_RegDst_in,
    input  logic         wb_RegWrite_in,
    input  logic         wb_MemtoReg_in,
    input  logic [A-1:0] rs_addr,
    input  logic [A-1:0] rt_addr,
    output logic [B-1:0] rs_data,
    output logic [B-1:0] rt_data,
    output logic [B-1:0] wb_data_out,
    output logic [31:0]  wb_count
);

    logic [B-1:0] regs_q [N_REG];
    logic [B-1:0] regs_d [N_REG];
    logic [31:0]  wb_count_q;
    logic [31:0]  wb_count_d;
    logic [A-1:0] waddr;
    logic         commit;
    logic         unused_regdst_bits;

    writeback_regfile_mux_memtoreg #(
        .B(B)
    ) u_mux_memtoreg (
        .mem_to_reg (wb_MemtoReg_in),
        .read_data  (read_data_in),
        .alu_result (alu_result_in),
        .wb_data    (wb_data_out)
    );

    // Upper destination bits carry no meaning here and are discarded.
    assign waddr              = mux_RegDst_in[A-1:0];
    assign unused_regdst_bits = ^mux_RegDst_in[B-1:A];

    // Commit qualifier; blocked during reset so bypass is suppressed too.
    always_comb begin
        commit = wb_RegWrite_in && (waddr != A'(REG_ZERO)) && !reset;
    end

    // Next-state for the register array and the commit counter.
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (commit) begin
            regs_d[waddr] = wb_data_out;
            wb_count_d    = wb_count_q + 32'd1;
        end
    end

    // State update; asynchronous clear of every register and the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REG; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Read ports: r0 reads zero, in-flight commit bypasses the array.
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (commit && (waddr == rs_addr)) begin
            rs_data = wb_data_out;
        end
        if (commit && (waddr == rt_addr)) begin
            rt_data = wb_data_out;
        end
        if (rs_addr == A'(REG_ZERO)) begin
            rs_data = '0;
        end
        if (rt_addr == A'(REG_ZERO)) begin
            rt_data = '0;
        end
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: select, commit, r0, bypass,
// address truncation, reset and counter wrap.
module tb_writeback_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] read_data_in;
    logic [31:0] alu_result_in;
    logic [31:0] mux_RegDst_in;
    logic        wb_RegWrite_in;
    logic        wb_MemtoReg_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data_out;
    logic [31:0] wb_count;

    int n_total;
    int n_bad;

    writeback_regfile dut (
        .clk            (clk),
        .reset          (reset),
        .read_data_in   (read_data_in),
        .alu_result_in  (alu_result_in),
        .mux_RegDst_in  (mux_RegDst_in),
        .wb_RegWrite_in (wb_RegWrite_in),
        .wb_MemtoReg_in (wb_MemtoReg_in),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .wb_data_out    (wb_data_out),
        .wb_count       (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // one active edge, then return just after the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [31:0] dst);
        wb_RegWrite_in = we;
        wb_MemtoReg_in = m2r;
        read_data_in   = rd;
        alu_result_in  = alu;
        mux_RegDst_in  = dst;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("reset_count", wb_count, 32'h0);
        chk("reset_rs", rs_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // step 1: load data selected, r7
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h11, 32'd7);
        rs_addr = 5'd7;
        #1;
        chk("sel_mem", wb_data_out, 32'hDEADBEEF);
        chk("bypass_r7", rs_data, 32'hDEADBEEF);
        tick();
        wb_RegWrite_in = 1'b0;
        #1;
        chk("r7_commit", rs_data, 32'hDEADBEEF);
        chk("count_1", wb_count, 32'd1);

        // step 2: ALU result selected, r8
        drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h11, 32'd8);
        #1;
        chk("sel_alu", wb_data_out, 32'h11);
        tick();
        wb_RegWrite_in = 1'b0;
        rt_addr = 5'd8;
        #1;
        chk("r8_commit", rt_data, 32'h11);
        chk("count_2", wb_count, 32'd2);

        // write to r0 is dropped
        drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd0);
        rs_addr = 5'd0;
        #1;
        chk("r0_before", rs_data, 32'h0);
        tick();
        #1;
        chk("r0_after", rs_data, 32'h0);
        chk("r0_count", wb_count, 32'd2);

        // bypass: set old r3, then present a new write without clocking it
        drive(1'b1, 1'b0, 32'h0, 32'hBEEF, 32'd3);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'hCAFE, 32'd3);
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        #1;
        chk("byp_rs", rs_data, 32'hCAFE);
        chk("byp_rt", rt_data, 32'hCAFE);
        wb_RegWrite_in = 1'b0;
        #1;
        chk("nobyp_rs", rs_data, 32'hBEEF);
        chk("nobyp_rt", rt_data, 32'hBEEF);
        tick();
        #1;
        chk("nowrite_r3", rs_data, 32'hBEEF);
        chk("count_3", wb_count, 32'd3);

        // address truncation
        drive(1'b1, 1'b0, 32'h0, 32'h55, 32'h24);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h66, 32'h20);
        rs_addr = 5'd4;
        rt_addr = 5'd0;
        #1;
        chk("trunc_r4", rs_data, 32'h55);
        tick();
        wb_RegWrite_in = 1'b0;
        #1;
        chk("trunc_r0", rt_data, 32'h0);
        chk("trunc_r4_kept", rs_data, 32'h55);
        chk("count_4", wb_count, 32'd4);

        // RegWrite low: no state change
        drive(1'b0, 1'b1, 32'h77, 32'h88, 32'd9);
        rs_addr = 5'd9;
        #1;
        chk("we0_sel", wb_data_out, 32'h77);
        tick();
        #1;
        chk("we0_r9", rs_data, 32'h0);
        chk("we0_count", wb_count, 32'd4);

        // mid-run asynchronous reset after r5 = 0x1234
        drive(1'b1, 1'b0, 32'h0, 32'h1234, 32'd5);
        tick();
        wb_RegWrite_in = 1'b0;
        rs_addr = 5'd5;
        #1;
        chk("r5_set", rs_data, 32'h1234);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_r5", rs_data, 32'h0);
        chk("arst_count", wb_count, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h999, 32'd5);
        #1;
        chk("arst_nobyp", rs_data, 32'h0);
        tick();
        #1;
        chk("arst_blocked", wb_count, 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_bypass", rs_data, 32'h999);
        tick();
        wb_RegWrite_in = 1'b0;
        #1;
        chk("rel_r5", rs_data, 32'h999);
        chk("rel_count", wb_count, 32'd1);

        // counter wrap via preload
        force dut.wb_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wb_count_q;
        drive(1'b1, 1'b0, 32'h0, 32'h1, 32'd6);
        rs_addr = 5'd6;
        tick();
        wb_RegWrite_in = 1'b0;
        #1;
        chk("wrap_count", wb_count, 32'h0);
        chk("wrap_r6", rs_data, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and general-purpose register file of the 5-stage pipeline. Consumes the registered outputs of the MEM/WB pipeline register and selects write-back data (memory read data vs. ALU result). It commits that data to a 32-entry register file and serves the two ID-stage read ports. Same-cycle write/read hazards are resolved by internal bypass, so ID never sees stale data for the instruction retiring in WB.

## Interface
Parameters:
- B, 32, data width in bits
- N_REG, 32, number of architectural registers (power of two)
- A, 5, register address width, log2(N_REG)

Ports:
- clk  in  1  sole clock; all state updates on posedge clk
- reset  in  1  asynchronous, active-high reset
- read_data_in  in  B  memory load data from MEM/WB
- alu_result_in  in  B  ALU result from MEM/WB
- mux_RegDst_in  in  B  destination register index from MEM/WB; only bits [A-1:0] are used
- wb_RegWrite_in  in  1  commit enable from MEM/WB
- wb_MemtoReg_in  in  1  1 = write read_data_in, 0 = write alu_result_in
- rs_addr  in  A  ID read port 1 address
- rt_addr  in  A  ID read port 2 address
- rs_data  out  B  ID read port 1 data
- rt_data  out  B  ID read port 2 data
- wb_data_out  out  B  selected write-back data, for EX forwarding
- wb_count  out  32  number of committed writes since reset

## Operation
- Write-back select (combinational): wb_data_out = wb_MemtoReg_in ? read_data_in : alu_result_in.
- Write address: waddr = mux_RegDst_in[A-1:0]; bits [B-1:A] are ignored and never checked.
- Commit condition: commit = wb_RegWrite_in && (waddr != 0).
- On commit, at posedge clk: regs[waddr] <= wb_data_out and wb_count <= wb_count + 1.
- wb_count is 32-bit and wraps from 0xFFFFFFFF to 0.
- Register 0:
  - Never written; always reads 0.
  - A write to register 0 is dropped and does not increment wb_count.
- Reads are combinational: rs_data = (rs_addr == 0) ? 0 : (commit && waddr == rs_addr) ? wb_data_out : regs[rs_addr]. rt_data follows the same rule with rt_addr.
- rs_addr == rt_addr: both ports return identical data, including the bypass case.
- wb_RegWrite_in = 0: no state change regardless of the other inputs. wb_MemtoReg_in still drives wb_data_out.
- Reset:
  - While reset is high, all regs[] = 0 and wb_count = 0.
  - rs_data and rt_data therefore read 0, and bypass is suppressed.
  - Commits are blocked while reset is high.
  - Deassertion mid-stream: the first posedge with reset low performs a normal commit of whatever MEM/WB presents.

## Timing
- Write latency: data committed at edge k is visible from regs[] after edge k. In the cycle before edge k it is already visible on rs_data/rt_data via bypass, giving effectively 0-cycle read-after-write for ID.
- Read latency: combinational. No read-side state and no handshake; the block is always ready.
- wb_count updates at the same edge as the register write.
- Reset is asynchronous: outputs derived from state go to 0 immediately on reset assertion, not at the next edge.

## Structure
- The shared definitions file holds:
  - B, N_REG, A
  - REG_ZERO = 0
  - MEMTOREG_MEM = 1 and MEMTOREG_ALU = 0 encodings, shared with the control unit and the MEM/WB register.
- One natural sub-module: mux_MemtoReg, a B-bit 2:1 select producing wb_data_out.
- The register array, bypass logic and counter stay in the top module.

## Test plan
- Reset: assert reset mid-run after writing r5 = 0x1234. Required: rs_addr = 5 reads 0 immediately; wb_count = 0.
- Select and commit:
  - Step 1: RegWrite = 1, MemtoReg = 1, read_data = 0xDEADBEEF, alu = 0x11, RegDst = 7, one edge. Required: rs_addr = 7 reads 0xDEADBEEF; wb_count = 1.
  - Step 2: repeat with MemtoReg = 0 and RegDst = 8. Required: r8 = 0x11.
- Zero register: RegWrite = 1, RegDst = 0, alu = 0xFFFFFFFF. Required: r0 reads 0 before and after the edge; wb_count unchanged.
- Bypass: RegWrite = 1, RegDst = 3, alu = 0xCAFE, rs_addr = rt_addr = 3, before the edge. Required: both read 0xCAFE in the same cycle. With RegWrite = 0, both read the old r3.
- Address truncation: RegDst = 0x00000024, alu = 0x55, one edge. Required: r4 = 0x55. With RegDst = 0x20, treated as r0 and dropped.
- Counter wrap: force 2^32 − 1 commits (or preload in simulation) and apply one more commit. Required: wb_count = 0.
